// File: rtl/axis_if.sv
// AXI-Stream style handshake bundle shared between manager and subordinate.
// Carries only tvalid/tready/tdata; width set by the instantiating context.
interface axis_if #(
  parameter int TDATA_WIDTH = 32
) ();
  logic                   tvalid;
  logic                   tready;
  logic [TDATA_WIDTH-1:0] tdata;

  modport m (output tvalid, output tdata, input tready);
  modport s (input tvalid, input tdata, output tready);
endinterface

// File: rtl/axis_elastic_buffer.sv
// Circular FIFO elastic buffer between two AXI-Stream ports; push-to-output latency 1 cycle.
// Upstream tready is registered from next occupancy, so downstream tready never reaches it combinationally.
module axis_elastic_buffer #(
  parameter int DEPTH       = 4,
  parameter int AFULL_LEVEL = DEPTH - 1
) (
  input  logic                         clk,
  input  logic                         rst,
  axis_if.s                            axis_sif,
  axis_if.m                            axis_mif,
  input  logic                         invalidate,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         almost_full
);

  localparam int TDATA_WIDTH = axis_mif.TDATA_WIDTH;
  localparam int PW          = $clog2(DEPTH);
  localparam int CW          = $clog2(DEPTH + 1);

  if (TDATA_WIDTH != axis_sif.TDATA_WIDTH) begin : g_bad_width_match
    $fatal(1, "axis_elastic_buffer: axis_sif and axis_mif TDATA_WIDTH differ");
  end
  if (TDATA_WIDTH == 0) begin : g_bad_width_zero
    $fatal(1, "axis_elastic_buffer: TDATA_WIDTH must be non-zero");
  end
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $fatal(1, "axis_elastic_buffer: DEPTH must be a power of two >= 2");
  end
  if ((AFULL_LEVEL < 1) || (AFULL_LEVEL > DEPTH)) begin : g_bad_afull
    $fatal(1, "axis_elastic_buffer: AFULL_LEVEL must be in 1..DEPTH");
  end

  logic [TDATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]          wr_ptr;
  logic [PW-1:0]          rd_ptr;
  logic [CW-1:0]          count_q;
  logic [CW-1:0]          count_nxt;
  logic                   tready_q;
  logic                   afull_q;
  logic                   push;
  logic                   pop;

  assign push            = axis_sif.tvalid && tready_q;
  assign pop             = axis_mif.tvalid && axis_mif.tready;
  assign axis_sif.tready = tready_q;
  assign axis_mif.tvalid = (count_q != '0);
  assign axis_mif.tdata  = mem[rd_ptr];
  assign count           = count_q;
  assign almost_full     = afull_q;

  // A flush wins over a concurrent push; a concurrent pop has already been consumed downstream.
  always_comb begin
    count_nxt = count_q;
    if (invalidate) begin
      count_nxt = '0;
    end else if (push && !pop) begin
      count_nxt = count_q + CW'(1);
    end else if (!push && pop) begin
      count_nxt = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count_q  <= '0;
      tready_q <= 1'b0;
      afull_q  <= 1'b0;
    end else begin
      count_q  <= count_nxt;
      tready_q <= (count_nxt < CW'(DEPTH));
      afull_q  <= (count_nxt >= CW'(AFULL_LEVEL));
      if (invalidate) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push && !invalidate) begin
      mem[wr_ptr] <= axis_sif.tdata;
    end
  end

endmodule

// File: tb/tb_axis_elastic_buffer.sv
// Directed and randomised stimulus for axis_elastic_buffer (DEPTH=4, 32-bit data)
// with a queue scoreboard checked by an independent output monitor.
module tb_axis_elastic_buffer;

  localparam int W     = 32;
  localparam int DEPTH = 4;
  localparam int NRAND = 10000;
  localparam int BUDGET = 60000;

  logic       clk = 1'b0;
  logic       rst;
  logic       invalidate;
  logic [2:0] count;
  logic       almost_full;

  axis_if #(.TDATA_WIDTH(W)) sif ();
  axis_if #(.TDATA_WIDTH(W)) mif ();

  axis_elastic_buffer #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .axis_sif    (sif),
    .axis_mif    (mif),
    .invalidate  (invalidate),
    .count       (count),
    .almost_full (almost_full)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         rx_count = 0;
  logic [W-1:0] sb [$];

  bit           stalled = 1'b0;
  logic [W-1:0] held;
  bit           accepted;
  int           src_n, src_cyc, snk_cyc, rx_base;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard writer: records accepted beats, drops everything on flush or reset.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (rst === 1'b1 || invalidate === 1'b1) sb.delete();
      else if (sif.tvalid === 1'b1 && sif.tready === 1'b1) sb.push_back(sif.tdata);
    end
  end

  // Output monitor: order check on every pop, stability check across every stall.
  initial begin
    forever begin
      @(negedge clk);
      if (stalled) begin
        check("stall_tvalid", {63'd0, mif.tvalid}, 64'd1);
        check("stall_tdata", {32'd0, mif.tdata}, {32'd0, held});
      end
      stalled = 1'b0;
      if (rst === 1'b0 && mif.tvalid === 1'b1 && mif.tready === 1'b1) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL pop_unexpected: got 0x%0h expected no beat at %0t", mif.tdata, $time);
        end else begin
          check("pop_order", {32'd0, mif.tdata}, {32'd0, sb.pop_front()});
        end
        rx_count++;
      end else if (rst === 1'b0 && invalidate === 1'b0 &&
                   mif.tvalid === 1'b1 && mif.tready === 1'b0) begin
        stalled = 1'b1;
        held    = mif.tdata;
      end
    end
  end

  initial begin
    rst        = 1'b1;
    invalidate = 1'b0;
    sif.tvalid = 1'b0;
    sif.tdata  = '0;
    mif.tready = 1'b0;

    // Reset state
    tick();
    check("rst_count", 64'(count), 64'd0);
    check("rst_tvalid", 64'(mif.tvalid), 64'd0);
    check("rst_tready", 64'(sif.tready), 64'd0);
    check("rst_afull", 64'(almost_full), 64'd0);
    rst = 1'b0;
    tick();
    check("post_rst_tready", 64'(sif.tready), 64'd1);

    // Streaming 0x1..0x10 with an always-ready sink
    mif.tready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      sif.tvalid = 1'b1;
      sif.tdata  = W'(i);
      tick();
      check("stream_count", 64'(count), 64'd1);
      check("stream_tvalid", 64'(mif.tvalid), 64'd1);
      check("stream_tdata", 64'(mif.tdata), 64'(i));
    end
    sif.tvalid = 1'b0;
    tick();
    check("stream_drain_count", 64'(count), 64'd0);
    check("stream_drain_tvalid", 64'(mif.tvalid), 64'd0);

    // Fill to full with the sink stalled
    mif.tready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      sif.tvalid = 1'b1;
      sif.tdata  = 32'hA0 + W'(k);
      tick();
      check("fill_count", 64'(count), 64'(k + 1));
      check("fill_afull", 64'(almost_full), 64'((k + 1) >= 3));
      check("fill_tready", 64'(sif.tready), 64'((k + 1) < 4));
    end
    sif.tdata = 32'hA4;
    tick();
    tick();
    check("full_hold_count", 64'(count), 64'd4);
    check("full_hold_tready", 64'(sif.tready), 64'd0);
    check("full_head", 64'(mif.tdata), 64'hA0);

    // One pop while full, then the pending beat enters at the wrapped pointer
    mif.tready = 1'b1;
    tick();
    mif.tready = 1'b0;
    check("pop_full_count", 64'(count), 64'd3);
    check("pop_full_tready", 64'(sif.tready), 64'd1);
    check("pop_full_head", 64'(mif.tdata), 64'hA1);
    tick();
    sif.tvalid = 1'b0;
    check("wrap_count", 64'(count), 64'd4);
    check("wrap_tready", 64'(sif.tready), 64'd0);
    mif.tready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      check("wrap_drain", 64'(mif.tdata), 64'(32'hA0 + k));
      tick();
    end
    mif.tready = 1'b0;
    check("wrap_empty", 64'(count), 64'd0);

    // Invalidate at count=3 with a concurrent push
    for (int k = 0; k < 3; k++) begin
      sif.tvalid = 1'b1;
      sif.tdata  = 32'hC0 + W'(k);
      tick();
    end
    check("pre_inv_count", 64'(count), 64'd3);
    check("pre_inv_afull", 64'(almost_full), 64'd1);
    invalidate = 1'b1;
    sif.tdata  = 32'hBEEF;
    tick();
    invalidate = 1'b0;
    sif.tvalid = 1'b0;
    check("inv_count", 64'(count), 64'd0);
    check("inv_tvalid", 64'(mif.tvalid), 64'd0);
    check("inv_tready", 64'(sif.tready), 64'd1);
    check("inv_afull", 64'(almost_full), 64'd0);
    mif.tready = 1'b1;
    repeat (4) tick();
    sif.tvalid = 1'b1;
    sif.tdata  = 32'hD0;
    tick();
    sif.tvalid = 1'b0;
    check("post_inv_tvalid", 64'(mif.tvalid), 64'd1);
    check("post_inv_tdata", 64'(mif.tdata), 64'hD0);
    tick();
    check("post_inv_empty", 64'(count), 64'd0);
    mif.tready = 1'b0;

    // Reset mid-operation at count=2
    for (int k = 0; k < 2; k++) begin
      sif.tvalid = 1'b1;
      sif.tdata  = 32'hE0 + W'(k);
      tick();
    end
    sif.tvalid = 1'b0;
    check("pre_rst_count", 64'(count), 64'd2);
    rst = 1'b1;
    tick();
    check("mid_rst_tvalid", 64'(mif.tvalid), 64'd0);
    check("mid_rst_tready", 64'(sif.tready), 64'd0);
    check("mid_rst_count", 64'(count), 64'd0);
    rst = 1'b0;
    tick();
    check("after_rst_tready", 64'(sif.tready), 64'd1);
    check("after_rst_tvalid", 64'(mif.tvalid), 64'd0);
    mif.tready = 1'b1;
    repeat (3) tick();
    mif.tready = 1'b0;

    // Random valid/ready stalls
    rx_base = rx_count;
    src_n   = 0;
    src_cyc = 0;
    snk_cyc = 0;
    fork
      begin
        while (src_n < NRAND && src_cyc < BUDGET) begin
          if (!sif.tvalid && $urandom_range(0, 3) != 0) begin
            sif.tvalid = 1'b1;
            sif.tdata  = 32'h1000_0000 + W'(src_n);
          end
          accepted = sif.tvalid && sif.tready;
          tick();
          src_cyc++;
          if (accepted) begin
            src_n++;
            sif.tvalid = 1'b0;
          end
        end
        sif.tvalid = 1'b0;
      end
      begin
        while ((rx_count - rx_base) < NRAND && snk_cyc < BUDGET) begin
          mif.tready = ($urandom_range(0, 2) != 0);
          tick();
          snk_cyc++;
        end
        mif.tready = 1'b0;
      end
    join
    check("rand_tx_count", 64'(src_n), 64'(NRAND));
    check("rand_rx_count", 64'(rx_count - rx_base), 64'(NRAND));
    check("rand_sb_empty", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axis_elastic_buffer.md
AXIS_ELASTIC_BUFFER -- requirements
Module: axis_elastic_buffer

Interface
REQ-001 The module SHALL have parameter DEPTH, default 4, meaning the number of stored beats (power of two, >= 2).
REQ-002 The module SHALL have parameter AFULL_LEVEL, default DEPTH-1, meaning the occupancy at or above which almost_full asserts (1..DEPTH).
REQ-003 The module SHALL have port clk  input  1  clock: single clock, all logic on its rising edge.
REQ-004 The module SHALL have port rst  input  1  reset: synchronous, active-high.
REQ-005 The module SHALL have port axis_sif  axis_if.s  TDATA_WIDTH  subordinate (upstream) stream: tvalid, tready, tdata.
REQ-006 The module SHALL have port axis_mif  axis_if.m  TDATA_WIDTH  manager (downstream) stream: tvalid, tready, tdata.
REQ-007 The module SHALL have port invalidate  input  1  synchronous flush of all stored beats.
REQ-008 The module SHALL have port count  output  $clog2(DEPTH+1)  current occupancy.
REQ-009 The module SHALL have port almost_full  output  1  high when count >= AFULL_LEVEL.
REQ-010 The module SHALL take TDATA_WIDTH from axis_mif and SHALL stop elaboration with a fatal error if it differs from axis_sif, is 0, or DEPTH is not a power of two >= 2.

Function
REQ-011 The module SHALL be a circular FIFO of DEPTH entries with write pointer, read pointer and occupancy count, all registered.
REQ-012 The module SHALL drive axis_sif.tready from a register equal to (next count < DEPTH), with no combinational path from axis_mif.tready to axis_sif.tready.
REQ-013 The module SHALL drive axis_mif.tvalid as (count != 0) and axis_mif.tdata from the entry at the read pointer, with both registered or from flops only.
REQ-014 The module SHALL make a push (s handshake) in cycle N visible on axis_mif in cycle N+1 when the buffer is empty (latency 1).
REQ-015 The module SHALL sustain one beat per cycle in both directions when 0 < count < DEPTH.
REQ-016 The module SHALL, on a simultaneous push and pop, leave count unchanged and advance both pointers.
REQ-017 The module SHALL, when full, hold tready low, and on a pop while full raise tready in the next cycle.
REQ-018 The module SHALL wrap pointers modulo DEPTH, and beats SHALL leave in push order.
REQ-019 The module SHALL hold axis_mif.tdata and tvalid stable while tvalid=1 and tready=0.
REQ-020 The module SHALL treat invalidate=1 as follows: count, pointers -> 0 next cycle; a push in the same cycle is discarded; a pop in the same cycle completes normally; tvalid=0 and tready=1 next cycle.
REQ-021 The module SHALL update almost_full and count in the same cycle as the occupancy change.

Reset
REQ-022 The module SHALL, while rst=1 at a clock edge, set pointers and count to 0, axis_mif.tvalid=0, almost_full=0, and axis_sif.tready=0.
REQ-023 The module SHALL set axis_sif.tready=1 on the first cycle after rst deasserts.
REQ-024 The module SHALL discard any stored beats on reset mid-operation, and storage contents SHALL need no reset.
REQ-025 The module SHALL give rst priority over invalidate.

Structure
REQ-026 The module SHALL use no new shared package types; the axis_if interface SHALL stay the only shared definition.
REQ-027 The module SHALL be a single module with no sub-module, storage being a flop array inferred in place.

Verification (DEPTH=4, TDATA_WIDTH=32)
REQ-028 The bench SHALL drive a continuous source and a ready-always sink, pushing 0x1..0x10, and SHALL see all 16 beats in order, one per cycle after 1-cycle latency, with count <= 1.
REQ-029 The bench SHALL hold the sink ready low and push 0xA0..0xA3, then SHALL see count=4, tready=0, almost_full=1 from count=3, and an attempted 0xA4 not accepted until after one pop.
REQ-030 The bench SHALL, when full, assert m ready for 1 cycle, then SHALL see 0xA0 leave, tready=1 next cycle, and a new push accepted at pointer wrap, order preserved.
REQ-031 The bench SHALL assert invalidate with count=3 and a simultaneous push of 0xBEEF, then SHALL see count=0 and tvalid=0 next cycle, with 0xBEEF never emitted.
REQ-032 The bench SHALL assert rst for 1 cycle with count=2, then SHALL see tvalid=0 and tready=0 during reset, tready=1 the following cycle, and no stale beats emitted.
REQ-033 The bench SHALL run random valid/ready stalls for 10k beats against a scoreboard with no loss, duplication or reorder, and an assertion that tdata is stable under stall.
